bip_control: RTL

BIP_CONTROL -- requirements
Module: bip_control

---
 rtl/bip_control.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bip_control.sv
// Control unit for a small accumulator processor: fetch/decode/execute sequencer
// with registered datapath strobes, program counter and retired-instruction counter.
module bip_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr_in,
  output logic [10:0] pc_out,
  output logic [10:0] operand,
  output logic [1:0]  sel_a,
  output logic        sel_b,
  output logic        wr_acc,
  output logic        op,
  output logic        wr_ram,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALT
  } state_t;

  typedef enum logic [4:0] {
    OPC_HLT  = 5'b00000,
    OPC_STO  = 5'b00001,
    OPC_LD   = 5'b00010,
    OPC_LDI  = 5'b00011,
    OPC_ADD  = 5'b00100,
    OPC_ADDI = 5'b00101,
    OPC_SUB  = 5'b00110,
    OPC_SUBI = 5'b00111
  } opcode_t;

  localparam logic [1:0] SRC_MEM = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_ALU = 2'b10;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op;
    logic       wr_ram;
  } ctrl_t;

  state_t      state;
  logic [10:0] pc;
  logic [15:0] ir;
  ctrl_t       ctrl;

  // Control word for one opcode; anything outside the defined set is a NOP.
  function automatic ctrl_t decode(input logic [4:0] opc);
    ctrl_t c;
    c = '0;
    case (opc)
      OPC_STO:  c.wr_ram = 1'b1;
      OPC_LD:   begin c.wr_acc = 1'b1; c.sel_a = SRC_MEM; end
      OPC_LDI:  begin c.wr_acc = 1'b1; c.sel_a = SRC_IMM; end
      OPC_ADD:  begin c.wr_acc = 1'b1; c.sel_a = SRC_ALU; c.sel_b = 1'b1; end
      OPC_ADDI: begin c.wr_acc = 1'b1; c.sel_a = SRC_ALU; end
      OPC_SUB:  begin c.wr_acc = 1'b1; c.sel_a = SRC_ALU; c.sel_b = 1'b1; c.op = 1'b1; end
      OPC_SUBI: begin c.wr_acc = 1'b1; c.sel_a = SRC_ALU; c.op = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // NOTE: reset is synchronous, so it lives inside the clocked block and is only seen on a rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
      ctrl    <= '0;
      halted  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
      ctrl <= '0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          // Strobes are registered here so they line up exactly with the EXECUTE cycle.
          ir    <= instr_in;
          ctrl  <= decode(instr_in[15:11]);
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          retired <= retired + 16'd1;
          if (ir[15:11] == OPC_HLT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            pc    <= pc + 11'd1;
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc_out  = pc;
  assign operand = ir[10:0];
  assign sel_a   = ctrl.sel_a;
  assign sel_b   = ctrl.sel_b;
  assign wr_acc  = ctrl.wr_acc;
  assign op      = ctrl.op;
  assign wr_ram  = ctrl.wr_ram;

endmodule
